// File: rtl/exibe_sequencia.sv
// ---------------------------------------------------------------------------
// exibe_sequencia
//
// Plays the stored game sequence back to the player. Starting at address 0 it
// reads every RAM entry up to and including the latched round index, shows
// each 4-bit entry on the LEDs for ON_CYCLES clocks, then keeps the LEDs dark
// for OFF_CYCLES clocks. When the last entry has been shown it pulses pronto
// for one cycle and returns to idle.
//
// Ports
//   clock      in   1  system clock, rising-edge active
//   reset      in   1  asynchronous active-high reset, returns to ESPERA
//   iniciar    in   1  start request, only honoured while idle (ESPERA)
//   rodada     in   4  index of the last entry to show, latched at start
//   mem_dado   in   4  sync RAM read data, valid one cycle after mem_addr
//   mem_addr   out  4  RAM address being read
//   leds       out  4  pattern shown to the player, 0 when dark
//   ocupado    out  1  high from ENDERECA through FIM
//   pronto     out  1  one-cycle pulse while in FIM
//   db_estado  out  4  current FSM state code for debug displays
//
// Per entry: ENDERECA, CARREGA, ON_CYCLES of LIGA, OFF_CYCLES of DESLIGA and
// PROXIMO, i.e. ON_CYCLES + OFF_CYCLES + 3 cycles.
// ---------------------------------------------------------------------------
module exibe_sequencia #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_addr,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  // Timer only ever has to reach max(ON_CYCLES, OFF_CYCLES) - 1.
  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    ENDERECA = 4'd1,
    CARREGA  = 4'd2,
    LIGA     = 4'd3,
    DESLIGA  = 4'd4,
    PROXIMO  = 4'd5,
    FIM      = 4'd6
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] timer_reg;
  logic [3:0]    rodada_reg;
  logic [3:0]    mem_addr_reg;
  logic [3:0]    leds_reg;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ESPERA;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = ESPERA;
    case (state_reg)
      ESPERA:   state_next = iniciar ? ENDERECA : ESPERA;
      ENDERECA: state_next = CARREGA;
      CARREGA:  state_next = LIGA;
      LIGA:     state_next = (timer_reg == ON_LAST) ? DESLIGA : LIGA;
      DESLIGA:  state_next = (timer_reg == OFF_LAST) ? PROXIMO : DESLIGA;
      // End check before the increment keeps mem_addr from wrapping at 15.
      PROXIMO:  state_next = (mem_addr_reg == rodada_reg) ? FIM : ENDERECA;
      FIM:      state_next = ESPERA;
      default:  state_next = ESPERA;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: timer, latched round, RAM address, LED pattern
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_reg    <= '0;
      rodada_reg   <= '0;
      mem_addr_reg <= '0;
      leds_reg     <= '0;
    end else begin
      // Timer restarts on every state entry and only runs in the timed states.
      if ((state_next != state_reg) ||
          ((state_reg != LIGA) && (state_reg != DESLIGA))) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end

      case (state_reg)
        ESPERA: begin
          leds_reg <= '0;
          if (iniciar) begin
            rodada_reg   <= rodada;
            mem_addr_reg <= '0;
          end
        end
        CARREGA: begin
          leds_reg <= mem_dado;
        end
        LIGA: begin
          if (state_next == DESLIGA) begin
            leds_reg <= '0;
          end
        end
        PROXIMO: begin
          if (state_next == ENDERECA) begin
            mem_addr_reg <= mem_addr_reg + 4'd1;
          end
        end
        ENDERECA, DESLIGA, FIM: begin
          leds_reg <= leds_reg;
        end
        default: begin
          leds_reg <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from the state register only
  // -------------------------------------------------------------------------
  always_comb begin
    ocupado   = 1'b0;
    pronto    = 1'b0;
    db_estado = state_reg;
    case (state_reg)
      ENDERECA, CARREGA, LIGA, DESLIGA, PROXIMO: ocupado = 1'b1;
      FIM: begin
        ocupado = 1'b1;
        pronto  = 1'b1;
      end
      default: begin
        ocupado = 1'b0;
        pronto  = 1'b0;
      end
    endcase
  end

  assign mem_addr = mem_addr_reg;
  assign leds     = leds_reg;

endmodule

// File: tb/tb_exibe_sequencia.sv
// ---------------------------------------------------------------------------
// tb_exibe_sequencia
//
// Drives table-driven playback runs against exibe_sequencia with a 1-cycle
// latency RAM model. For each run the expected per-cycle output trace is
// derived from the playback timing (entry length ON+OFF+3, first lit cycle 3)
// and queued when the start pulse is driven, then popped and compared at
// every falling edge. A hand-written sequence covers reset mid-run.
// ---------------------------------------------------------------------------
module tb_exibe_sequencia;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int E   = ON + OFF + 3;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] rodada;
  logic [3:0] mem_dado;
  logic [3:0] mem_addr;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rodada;
    logic [63:0] img;
    int          poke_a;      // cycle to re-pulse iniciar (0 = none)
    int          poke_b;      // second re-pulse cycle (0 = none)
    int          new_rodada;  // value driven on rodada at poke_a
    int          pronto_cyc;  // expected cycle of the pronto pulse
  } vec_t;

  typedef struct {
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db;
    logic [3:0] addr;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  exibe_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .rodada    (rodada),
    .mem_dado  (mem_dado),
    .mem_addr  (mem_addr),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM, 1-cycle read latency.
  always @(posedge clock) mem_dado <= mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs during cycle k (k=1 is the cycle after the start edge).
  function automatic exp_t model(input int k, input int r, input logic [63:0] img);
    exp_t m;
    int   step;
    int   ph;
    m.leds = 4'd0; m.ocupado = 1'b0; m.pronto = 1'b0; m.db = 4'd0; m.addr = 4'(r);
    if (k >= 1 && k <= E * (r + 1)) begin
      step      = (k - 1) / E;
      ph        = (k - 1) % E;
      m.ocupado = 1'b1;
      m.addr    = 4'(step);
      if (ph == 0)               m.db = 4'd1;
      else if (ph == 1)          m.db = 4'd2;
      else if (ph < 2 + ON) begin
        m.db   = 4'd3;
        m.leds = img[4*step +: 4];
      end
      else if (ph < 2 + ON + OFF) m.db = 4'd4;
      else                        m.db = 4'd5;
    end else if (k == E * (r + 1) + 1) begin
      m.db      = 4'd6;
      m.ocupado = 1'b1;
      m.pronto  = 1'b1;
    end
    return m;
  endfunction

  task automatic load_mem(input logic [63:0] img);
    for (int i = 0; i < 16; i++) mem[i] = img[4*i +: 4];
  endtask

  task automatic run_vector(input int vi);
    vec_t v;
    exp_t e;
    int   n;
    int   pcount;
    int   pcyc;
    v = vecs[vi];
    load_mem(v.img);
    n = E * (v.rodada + 1) + 4;
    // Scoreboard filled when the stimulus is driven.
    for (int k = 1; k <= n; k++) sb.push_back(model(k, v.rodada, v.img));
    pcount = 0;
    pcyc   = -1;
    @(negedge clock);
    rodada  = 4'(v.rodada);
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      chk($sformatf("v%0d c%0d leds", vi, k), leds, e.leds);
      chk($sformatf("v%0d c%0d ocupado", vi, k), ocupado, e.ocupado);
      chk($sformatf("v%0d c%0d pronto", vi, k), pronto, e.pronto);
      chk($sformatf("v%0d c%0d db_estado", vi, k), db_estado, e.db);
      chk($sformatf("v%0d c%0d mem_addr", vi, k), mem_addr, e.addr);
      if (pronto) begin
        pcount++;
        pcyc = k;
      end
      if (k == v.poke_a || k == v.poke_b) begin
        if (k == v.poke_a) rodada = 4'(v.new_rodada);
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
      end
    end
    chk($sformatf("v%0d pronto_count", vi), pcount, 1);
    chk($sformatf("v%0d pronto_cycle", vi), pcyc, v.pronto_cyc);
    $display("run %0d: rodada=%0d pronto@%0d pulses=%0d checks=%0d errors=%0d",
             vi, v.rodada, pcyc, pcount, checks, errors);
  endtask

  task automatic reset_mid_run();
    load_mem(vecs[1].img);
    @(negedge clock);
    rodada  = 4'd3;
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    repeat (4) @(negedge clock);  // cycle 4, inside LIGA of entry 0
    chk("rst pre leds", leds, 1);
    chk("rst pre db_estado", db_estado, 3);
    #2 reset = 1'b1;
    #1;
    chk("rst leds", leds, 0);
    chk("rst ocupado", ocupado, 0);
    chk("rst pronto", pronto, 0);
    chk("rst db_estado", db_estado, 0);
    chk("rst mem_addr", mem_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("rst idle c%0d db_estado", k), db_estado, 0);
      chk($sformatf("rst idle c%0d ocupado", k), ocupado, 0);
    end
    $display("reset mid-run: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    vecs[0] = '{0,  64'hAAAA_AAAA_AAAA_AAA1, 0, 0,  0, 10};
    vecs[1] = '{3,  64'hAAAA_AAAA_AAAA_8421, 0, 0,  0, 37};
    vecs[2] = '{15, 64'h0FED_CBA9_8765_4321, 0, 0,  0, 145};
    vecs[3] = '{3,  64'hAAAA_AAAA_AAAA_8421, 4, 37, 9, 37};
    vecs[4] = '{2,  64'hAAAA_AAAA_AAAA_A503, 0, 0,  0, 28};
    vecs[5] = '{1,  64'hAAAA_AAAA_AAAA_AA96, 0, 0,  0, 19};

    reset   = 1'b1;
    iniciar = 1'b0;
    rodada  = 4'd0;
    load_mem(64'h0);
    repeat (2) @(negedge clock);
    chk("reset leds", leds, 0);
    chk("reset ocupado", ocupado, 0);
    chk("reset pronto", pronto, 0);
    chk("reset db_estado", db_estado, 0);
    chk("reset mem_addr", mem_addr, 0);
    reset = 1'b0;
    $display("reset state: checks=%0d errors=%0d", checks, errors);

    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_mid_run();
      run_vector(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
